hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage CPU.
- Keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB control fields: rs1, rs2, rd, RegWrite, MemRead, Mul.
- Drives the 2-bit select lines of the two EX-stage operand forwarding muxes.
- Sequences load-use stalls and multi-cycle multiply holds, and applies branch flushes to the ID entry.

Parameters:
- MUL_LAT, 3, cycles a multiply occupies EX; legal range >= 1.
- RA_W, 5, register address width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- id_valid_i  input  1  ID holds a real instruction.
- id_rs1_i  input  RA_W  ID source register 1.
- id_rs2_i  input  RA_W  ID source register 2.
- id_rd_i  input  RA_W  ID destination register.
- id_regwrite_i  input  1  ID instruction writes rd.
- id_memread_i  input  1  ID instruction is a load.
- id_mul_i  input  1  ID instruction is a multi-cycle multiply.
- flush_i  input  1  branch taken; squash the ID entry.
- ForwardA_o  output  2  EX operand-A mux select: 00 register file, 01 WB result, 10 MEM result.
- ForwardB_o  output  2  same encoding, operand B.
- stall_o  output  1  hold PC and IF/ID.
- bubble_o  output  1  zero ID/EX control (insert NOP into EX).
- ex_hold_o  output  1  freeze ID/EX; EX/MEM loads a bubble.

Behaviour:
- Internal stage entries EX, MEM, WB. Each holds valid, rs1, rs2, rd, regwrite, memread, mul.
- Reset (async, rst_i=1): all entries invalid with zero fields; mul counter = 0.
  - ForwardA_o = ForwardB_o = 00.
  - stall_o = bubble_o = ex_hold_o = 0.
- Forward select (combinational from registered EX/MEM/WB entries only; no dependence on ID inputs):
  - 10 if MEM valid & regwrite & rd != 0 & rd == EX.rs.
  - else 01 if the same condition holds for WB.
  - else 00.
  - MEM has priority over WB. Value 11 is never driven.
  - An EX bubble yields 00.
- Load-use hazard (combinational): luh = id_valid_i & EX.valid & EX.memread & EX.rd != 0 & (EX.rd == id_rs1_i | EX.rd == id_rs2_i).
- Mul counter:
  - Loaded with MUL_LAT-1 on the edge a mul entry enters EX.
  - Decrements each cycle while non-zero.
  - ex_hold_o = (counter != 0).
- Outputs:
  - ex_hold_o as above.
  - stall_o = luh | ex_hold_o.
  - bubble_o = luh & ~ex_hold_o.
- Per-edge update, in priority order:
  1. ex_hold: EX and ID are unchanged. MEM <- bubble. WB <- old MEM. flush_i is not consumed; the requester holds it until hold clears.
  2. luh: EX <- bubble. MEM <- old EX. WB <- old MEM. ID is held and re-evaluated next cycle, so exactly 1 bubble per load-use.
  3. Normal: WB <- MEM, MEM <- EX, EX <- ID entry. The ID entry becomes a bubble if id_valid_i = 0 or flush_i = 1.
- Simultaneous events:
  - flush_i with luh: the flush wins. The ID entry is discarded, EX gets a bubble, stall_o is deasserted (luh is masked by flush_i).
  - MUL_LAT = 1: the counter is never non-zero; a multiply behaves as a single-cycle op.
- Reset mid-hold or mid-stall: everything clears immediately; no pending bubble is remembered.
- Latency: forward selects are valid in the same cycle the consumer is in EX. Stall/bubble decisions are combinational in the cycle the dependent instruction is in ID.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds two outputs:
  - luh_cnt_o (32-bit): cycles with bubble_o = 1.
  - hold_cnt_o (32-bit): cycles with ex_hold_o = 1.
- Both counters are reset to 0 by rst_i and saturate at 0xFFFFFFFF.
- When undefined: no such ports and no counter logic.

Test Plan:
- ALU chain "add x5,x1,x2" then "sub x6,x5,x3": when sub is in EX -> ForwardA_o = 10, ForwardB_o = 00, no stall.
- Distance-2 dependency "add x5", NOP, "or x7,x4,x5": -> ForwardB_o = 01. With x5 written at both MEM and WB -> 10 (MEM priority). With rd = x0 -> 00.
- "lw x8,0(x1)" then "add x9,x8,x8": -> one cycle with stall_o = 1 and bubble_o = 1. Next cycle the add enters EX with ForwardA_o = ForwardB_o = 01.
- MUL_LAT = 3, "mul x10" then "add x11,x10,x0": -> ex_hold_o high 2 cycles, MEM bubbles, then the add gets ForwardA_o = 10.
- luh together with flush_i = 1: -> stall_o = 0 and EX receives a bubble. Async reset asserted mid mul hold: -> all outputs 0 immediately; the counter is cleared (and statistics counters too when HAZARD_STATS_EN is defined).

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Hazard and forwarding controller for the 5-stage pipeline. It keeps a
//   shadow copy of the EX, MEM and WB control fields and uses them to drive
//   the EX operand forwarding selects. It also sequences load-use stalls,
//   multi-cycle multiply holds and branch flushes of the ID entry.
//
//   Parameters: MUL_LAT (cycles a multiply occupies EX, >= 1), RA_W (reg addr width)
//   Ports:
//     clk_i, rst_i                 clock, async active-high reset
//     id_*_i                       ID-stage instruction control fields
//     flush_i                      branch taken, squash the ID entry
//     ForwardA_o / ForwardB_o      00 regfile, 01 WB result, 10 MEM result
//     stall_o                      hold PC and IF/ID
//     bubble_o                     insert a NOP into EX
//     ex_hold_o                    freeze ID/EX, EX/MEM loads a bubble
//   Optional (macro HAZARD_STATS_EN):
//     luh_cnt_o, hold_cnt_o        saturating counts of bubble / hold cycles
module hazard_fwd_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned RA_W    = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic            id_regwrite_i,
  input  logic            id_memread_i,
  input  logic            id_mul_i,
  input  logic            flush_i,
  output logic [1:0]      ForwardA_o,
  output logic [1:0]      ForwardB_o,
  output logic            stall_o,
  output logic            bubble_o,
  output logic            ex_hold_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     luh_cnt_o,
  output logic [31:0]     hold_cnt_o
`endif
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
    logic            mul;
  } entry_t;

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  entry_t id_entry;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic luh;

  // The WB shadow is kept complete, but only its write-back fields feed logic.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rs1, wb_q.rs2, wb_q.memread, wb_q.mul};

  function automatic logic [1:0] fwd_sel(input entry_t ex, input entry_t mem,
                                         input entry_t wb, input logic [RA_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex.valid) begin
      if (mem.valid && mem.regwrite && (mem.rd != '0) && (mem.rd == rs))
        sel = 2'b10;
      else if (wb.valid && wb.regwrite && (wb.rd != '0) && (wb.rd == rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardA_o = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs1);
    ForwardB_o = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs2);
  end

  // A flush discards the dependent instruction, so it can never cause a stall.
  always_comb begin
    luh = id_valid_i && !flush_i && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
          ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    ex_hold_o = (cnt_q != '0);
    stall_o   = luh || ex_hold_o;
    bubble_o  = luh && !ex_hold_o;
  end

  always_comb begin
    id_entry = '0;
    if (id_valid_i && !flush_i) begin
      id_entry.valid    = 1'b1;
      id_entry.rs1      = id_rs1_i;
      id_entry.rs2      = id_rs2_i;
      id_entry.rd       = id_rd_i;
      id_entry.regwrite = id_regwrite_i;
      id_entry.memread  = id_memread_i;
      id_entry.mul      = id_mul_i;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (ex_hold_o) begin
      // Multiply still busy: it stays in EX while the rest of the pipe drains.
      mem_d = '0;
      wb_d  = mem_q;
      cnt_d = cnt_q - 1'b1;
    end else if (luh) begin
      ex_d  = '0;
      mem_d = ex_q;
      wb_d  = mem_q;
    end else begin
      ex_d  = id_entry;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (id_entry.valid && id_entry.mul)
        cnt_d = CNT_LOAD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] luh_cnt_q, luh_cnt_d, hold_cnt_q, hold_cnt_d;

  always_comb begin
    luh_cnt_d  = luh_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (bubble_o && (luh_cnt_q != 32'hFFFF_FFFF))
      luh_cnt_d = luh_cnt_q + 32'd1;
    if (ex_hold_o && (hold_cnt_q != 32'hFFFF_FFFF))
      hold_cnt_d = hold_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      luh_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      luh_cnt_q  <= luh_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign luh_cnt_o  = luh_cnt_q;
  assign hold_cnt_o = hold_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic       id_regwrite_i = 1'b0, id_memread_i = 1'b0, id_mul_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [1:0] ForwardA_o, ForwardB_o;
  logic       stall_o, bubble_o, ex_hold_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] luh_cnt_o, hold_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  hazard_fwd_ctrl #(.MUL_LAT(3), .RA_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .id_mul_i(id_mul_i),
    .flush_i(flush_i),
    .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
    .stall_o(stall_o), .bubble_o(bubble_o), .ex_hold_o(ex_hold_o)
`ifdef HAZARD_STATS_EN
    , .luh_cnt_o(luh_cnt_o), .hold_cnt_o(hold_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // valid, rs1, rs2, rd, regwrite, memread, mul; then let combinational logic settle
  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic ml);
    id_valid_i = v; id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd;
    id_regwrite_i = rw; id_memread_i = mr; id_mul_i = ml;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_fa", 32'(ForwardA_o), 32'd0);
    chk("rst_fb", 32'(ForwardB_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_bubble", 32'(bubble_o), 32'd0);
    chk("rst_hold", 32'(ex_hold_o), 32'd0);
`ifdef HAZARD_STATS_EN
    chk("rst_luh_cnt", luh_cnt_o, 32'd0);
    chk("rst_hold_cnt", hold_cnt_o, 32'd0);
`endif
    rst_i = 1'b0;

    // add x5,x1,x2 ; sub x6,x5,x3
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    tick();
    set_id(1, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    chk("alu_id_stall", 32'(stall_o), 32'd0);
    tick();
    nop();
    chk("alu_fa", 32'(ForwardA_o), 32'd2);
    chk("alu_fb", 32'(ForwardB_o), 32'd0);
    chk("alu_stall", 32'(stall_o), 32'd0);

    // add x5 ; nop ; or x7,x4,x5
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    tick();
    nop();
    tick();
    set_id(1, 5'd4, 5'd5, 5'd7, 1, 0, 0);
    tick();
    nop();
    chk("d2_fa", 32'(ForwardA_o), 32'd0);
    chk("d2_fb", 32'(ForwardB_o), 32'd1);

    // add x5 ; add x5 ; or x7,x5,x4  -> MEM wins
    set_id(1, 5'd1, 5'd1, 5'd5, 1, 0, 0);
    tick();
    set_id(1, 5'd2, 5'd3, 5'd5, 1, 0, 0);
    tick();
    set_id(1, 5'd5, 5'd4, 5'd7, 1, 0, 0);
    tick();
    nop();
    chk("prio_fa", 32'(ForwardA_o), 32'd2);
    chk("prio_fb", 32'(ForwardB_o), 32'd0);

    // add x0 ; nop ; or x7,x0,x0 -> never forward x0
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 0, 0);
    tick();
    nop();
    tick();
    set_id(1, 5'd0, 5'd0, 5'd7, 1, 0, 0);
    tick();
    nop();
    chk("x0_fa", 32'(ForwardA_o), 32'd0);
    chk("x0_fb", 32'(ForwardB_o), 32'd0);

    // producer without regwrite -> no forward
    set_id(1, 5'd1, 5'd2, 5'd5, 0, 0, 0);
    tick();
    set_id(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
    tick();
    nop();
    chk("norw_fa", 32'(ForwardA_o), 32'd0);

    // lw x8,0(x1) ; add x9,x8,x8
    set_id(1, 5'd1, 5'd0, 5'd8, 1, 1, 0);
    tick();
    set_id(1, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    chk("luh_stall", 32'(stall_o), 32'd1);
    chk("luh_bubble", 32'(bubble_o), 32'd1);
    chk("luh_hold", 32'(ex_hold_o), 32'd0);
    tick();
    chk("luh_stall2", 32'(stall_o), 32'd0);
    chk("luh_bubble2", 32'(bubble_o), 32'd0);
    tick();
    nop();
    chk("luh_fa", 32'(ForwardA_o), 32'd1);
    chk("luh_fb", 32'(ForwardB_o), 32'd1);

    // lw x8 ; add x9,x1,x2 (independent) -> no stall
    set_id(1, 5'd1, 5'd0, 5'd8, 1, 1, 0);
    tick();
    set_id(1, 5'd1, 5'd2, 5'd9, 1, 0, 0);
    chk("nodep_stall", 32'(stall_o), 32'd0);
    tick();

    // mul x10,x9,x2 ; add x11,x10,x0
    set_id(1, 5'd9, 5'd2, 5'd10, 1, 0, 1);
    tick();
    set_id(1, 5'd10, 5'd0, 5'd11, 1, 0, 0);
    chk("mul_hold1", 32'(ex_hold_o), 32'd1);
    chk("mul_stall1", 32'(stall_o), 32'd1);
    chk("mul_bubble1", 32'(bubble_o), 32'd0);
    chk("mul_fa1", 32'(ForwardA_o), 32'd2);
    tick();
    chk("mul_hold2", 32'(ex_hold_o), 32'd1);
    chk("mul_fa2", 32'(ForwardA_o), 32'd1);
    tick();
    chk("mul_hold3", 32'(ex_hold_o), 32'd0);
    chk("mul_stall3", 32'(stall_o), 32'd0);
    chk("mul_fa3", 32'(ForwardA_o), 32'd0);
    tick();
    nop();
    chk("mul_use_fa", 32'(ForwardA_o), 32'd2);
    chk("mul_use_fb", 32'(ForwardB_o), 32'd0);

    // lw x8 ; add x9,x8,x8 with flush -> no stall, EX gets a bubble
    set_id(1, 5'd1, 5'd0, 5'd8, 1, 1, 0);
    tick();
    flush_i = 1'b1;
    set_id(1, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_bubble", 32'(bubble_o), 32'd0);
    tick();
    flush_i = 1'b0;
    set_id(1, 5'd9, 5'd0, 5'd13, 1, 0, 0);
    tick();
    nop();
    chk("flush_fa", 32'(ForwardA_o), 32'd0);

    // add x3 ; mul x10,x3,x3 then reset during the hold
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
    tick();
    set_id(1, 5'd3, 5'd3, 5'd10, 1, 0, 1);
    tick();
    nop();
    chk("pre_rst_hold", 32'(ex_hold_o), 32'd1);
    chk("pre_rst_fa", 32'(ForwardA_o), 32'd2);
    chk("pre_rst_fb", 32'(ForwardB_o), 32'd2);
`ifdef HAZARD_STATS_EN
    chk("pre_rst_luh_cnt", luh_cnt_o, 32'd1);
    chk("pre_rst_hold_cnt", hold_cnt_o, 32'd2);
`endif
    #1 rst_i = 1'b1;
    #1;
    chk("mid_rst_hold", 32'(ex_hold_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_bubble", 32'(bubble_o), 32'd0);
    chk("mid_rst_fa", 32'(ForwardA_o), 32'd0);
    chk("mid_rst_fb", 32'(ForwardB_o), 32'd0);
`ifdef HAZARD_STATS_EN
    chk("mid_rst_luh_cnt", luh_cnt_o, 32'd0);
    chk("mid_rst_hold_cnt", hold_cnt_o, 32'd0);
`endif
    rst_i = 1'b0;
    tick();
    chk("post_rst_hold", 32'(ex_hold_o), 32'd0);
    chk("post_rst_stall", 32'(stall_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
